eth_tx_frame_arbiter: RTL and testbench
=======================================

# eth_tx_frame_arbiter

Packet-level round-robin arbiter and minimum-length padder on the transmit path, in the `logic_clk` domain. It merges two byte-wide valid/ready/last frame sources into the single MAC transmit input (`mac_rnet_*`):

- the ARP responder (`arp_tx_*`);
- the IP/UDP encapsulator (`ip_tx_*`).

A granted frame is never interleaved with the other source. Frames shorter than `MIN_FRAME_BYTES` are zero-padded, so the downstream CRC stage always receives a legal-length Ethernet frame (DA through payload, no FCS).

## Interface
- `MIN_FRAME_BYTES`, 60: minimum frame length in bytes, FCS excluded. Legal range 1–2047.
- `CNT_WIDTH`, 11: width of the byte counter. Must satisfy 2^CNT_WIDTH > `MIN_FRAME_BYTES`.
- `logic_clk` in 1: the only clock.
- `logic_rst` in 1: synchronous, active-high reset.
- `arp_tx_data_in` in 8: ARP source byte.
- `arp_tx_valid_in` in 1: ARP byte valid.
- `arp_tx_ready_out` out 1: ARP byte accepted when valid && ready.
- `arp_tx_last_in` in 1: final byte of the ARP frame.
- `ip_tx_data_in` in 8: IP source byte.
- `ip_tx_valid_in` in 1: IP byte valid.
- `ip_tx_ready_out` out 1: IP byte accepted when valid && ready.
- `ip_tx_last_in` in 1: final byte of the IP frame.
- `mac_rnet_data_out` out 8: byte to the MAC transmit input.
- `mac_rnet_valid_out` out 1: output byte valid.
- `mac_rnet_ready_in` in 1: MAC accepts the byte when valid && ready.
- `mac_rnet_last_out` out 1: final byte of the output frame.
- `arb_grant_out` out 2: current grant. 2'b00 none, 2'b01 ARP, 2'b10 IP.

## Operation
- States: IDLE, SEND, PAD.
- Output stage is a single register holding data, valid and last.
  - `out_free` = !`mac_rnet_valid_out` || `mac_rnet_ready_in`.
  - When `out_free` is set and nothing is loaded, valid clears.
- **IDLE**
  - Both source readys are 0. `arb_grant_out` = 0.
  - If any source is valid: latch the grant, clear `byte_cnt`, go to SEND.
  - Tie-break uses the round-robin pointer `rr`: the source not served last wins.
  - `rr` resets to "IP served last", so ARP wins the first tie.
  - A single valid source wins regardless of `rr`.
- **SEND**
  - Granted source ready = `out_free`. The ungranted source ready is 0.
  - On each accepted byte:
    - load the output register with that byte;
    - `byte_cnt` increments, saturating at 2^CNT_WIDTH−1.
  - On an accepted byte with last=1:
    - if `byte_cnt`+1 ≥ `MIN_FRAME_BYTES`: output last=1, update `rr` to the granted source, go to IDLE;
    - else: output last=0, go to PAD.
  - Source `last` is ignored unless the source is granted and the byte is accepted.
- **PAD**
  - Both source readys are 0.
  - Each cycle `out_free` is set: load 0x00 and increment `byte_cnt`.
  - On the byte where `byte_cnt`+1 == `MIN_FRAME_BYTES`: last=1, update `rr`, go to IDLE.
- Long frames pass through unmodified; the counter saturates and no truncation is applied.
- **Reset**: applies on any cycle, including mid-frame. The partial frame is dropped with no trailing last.
  - After the reset edge: state IDLE, `rr` = IP, `byte_cnt` = 0.
  - Output register cleared: `mac_rnet_valid_out`, `mac_rnet_last_out` = 0, `mac_rnet_data_out` = 0x00.
  - Both readys = 0, `arb_grant_out` = 0.

## Timing
- Source valid seen in IDLE at cycle N:
  - grant visible and ready high at N+1, provided `out_free`;
  - first byte on `mac_rnet_*` at N+2.
- One IDLE cycle separates consecutive frames, so the inter-frame overhead is one cycle.
- Steady-state throughput is 1 byte/cycle when `mac_rnet_ready_in` = 1.
- Source readys are combinational from `mac_rnet_ready_in`. No other input-to-output combinational paths exist.
- While valid && !`mac_rnet_ready_in`, data and last hold stable and no source byte is accepted.
- Pad bytes follow the last source byte with no gap when ready = 1.
- `rr` updates on the cycle the last output byte is loaded, not when it is consumed.

## Test plan
- **ARP pad**: ARP frame of 42 bytes (0x01..0x2A), ready=1.
  - Output: 60 bytes — 0x01..0x2A then eighteen 0x00.
  - last only on byte 60. `arp_tx_ready_out` = 0 during PAD.
- **IP pass-through**: IP frame of 100 bytes, ready=1.
  - Output: 100 identical bytes, last on byte 100, no pad.
  - First output byte 2 cycles after valid rises.
- **Length boundaries**:
  - 60-byte frame → 60 bytes out, no PAD state.
  - 59-byte frame → 60 bytes out, byte 60 = 0x00 with last.
  - 1-byte frame → 60 bytes out.
- **Arbitration**: after reset, ARP and IP both valid with 64-byte frames, held continuously.
  - Grant order: ARP, IP, ARP, IP.
  - No interleaving. Exactly one IDLE cycle between frames (`arb_grant_out` = 0).
- **Backpressure**: 80-byte IP frame with `mac_rnet_ready_in` pattern 1,0,0,1 repeating.
  - Output sequence is byte-exact with no loss or duplication.
  - Data stable during stalls. Source readys follow `out_free`.
- **Mid-frame reset**: assert `logic_rst` for 1 cycle after byte 20 of a 42-byte ARP frame.
  - Next cycle: all outputs 0.
  - A subsequent IP frame of 70 bytes is delivered intact.
  - A new tie is won by ARP (`rr` reset).

Source files
------------

// File: rtl/eth_tx_frame_arbiter.sv
// Purpose: round-robin packet arbiter (ARP vs IP) with zero padding up to MIN_FRAME_BYTES.
// Latency: source valid in IDLE at cycle N -> grant at N+1 -> first output byte at N+2.
// Backpressure: source ready follows the single output register's free slot; stalls hold data/last.
module eth_tx_frame_arbiter #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int CNT_WIDTH       = 11
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] arp_tx_data_in,
    input  logic       arp_tx_valid_in,
    output logic       arp_tx_ready_out,
    input  logic       arp_tx_last_in,
    input  logic [7:0] ip_tx_data_in,
    input  logic       ip_tx_valid_in,
    output logic       ip_tx_ready_out,
    input  logic       ip_tx_last_in,
    output logic [7:0] mac_rnet_data_out,
    output logic       mac_rnet_valid_out,
    input  logic       mac_rnet_ready_in,
    output logic       mac_rnet_last_out,
    output logic [1:0] arb_grant_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_ARP  = 2'b01;
    localparam logic [1:0] GNT_IP   = 2'b10;

    localparam logic [CNT_WIDTH:0]   MIN_LEN = MIN_FRAME_BYTES[CNT_WIDTH:0];
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q;
    logic [1:0]           grant_q;
    logic                 rr_ip_last_q;   // 1: IP was served last, so ARP wins the next tie
    logic [CNT_WIDTH-1:0] byte_cnt_q;
    logic [CNT_WIDTH-1:0] byte_cnt_d;
    logic [CNT_WIDTH:0]   cnt_plus1;
    logic [7:0]           out_dat_q;
    logic                 out_vld_q;
    logic                 out_last_q;

    logic       out_free;
    logic       src_vld;
    logic [7:0] src_dat;
    logic       src_last;
    logic       src_acc;
    logic       reached_min;
    logic       pad_done;
    logic       arp_wins;

    assign out_free = !out_vld_q || mac_rnet_ready_in;

    // Mux the granted source and derive counter comparisons for the current byte.
    always_comb begin
        src_vld  = 1'b0;
        src_dat  = 8'h00;
        src_last = 1'b0;
        if (grant_q == GNT_ARP) begin
            src_vld  = arp_tx_valid_in;
            src_dat  = arp_tx_data_in;
            src_last = arp_tx_last_in;
        end else if (grant_q == GNT_IP) begin
            src_vld  = ip_tx_valid_in;
            src_dat  = ip_tx_data_in;
            src_last = ip_tx_last_in;
        end
        cnt_plus1   = {1'b0, byte_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        byte_cnt_d  = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : cnt_plus1[CNT_WIDTH-1:0];
        reached_min = (cnt_plus1 >= MIN_LEN);
        pad_done    = (cnt_plus1 == MIN_LEN);
        src_acc     = (state_q == ST_SEND) && src_vld && out_free;
        arp_wins    = arp_tx_valid_in && (!ip_tx_valid_in || rr_ip_last_q);
    end

    // Source readys are the only combinational input-to-output paths.
    assign arp_tx_ready_out   = (state_q == ST_SEND) && (grant_q == GNT_ARP) && out_free;
    assign ip_tx_ready_out    = (state_q == ST_SEND) && (grant_q == GNT_IP)  && out_free;
    assign mac_rnet_data_out  = out_dat_q;
    assign mac_rnet_valid_out = out_vld_q;
    assign mac_rnet_last_out  = out_last_q;
    assign arb_grant_out      = grant_q;

    // Arbitration / send / pad FSM together with the output register.
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            rr_ip_last_q <= 1'b1;
            byte_cnt_q   <= '0;
            out_dat_q    <= 8'h00;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (out_free) begin
                        out_vld_q <= 1'b0;
                    end
                    if (arp_tx_valid_in || ip_tx_valid_in) begin
                        grant_q    <= arp_wins ? GNT_ARP : GNT_IP;
                        byte_cnt_q <= '0;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (src_acc) begin
                        out_dat_q  <= src_dat;
                        out_vld_q  <= 1'b1;
                        byte_cnt_q <= byte_cnt_d;
                        out_last_q <= 1'b0;
                        if (src_last) begin
                            if (reached_min) begin
                                out_last_q   <= 1'b1;
                                rr_ip_last_q <= (grant_q == GNT_IP);
                                grant_q      <= GNT_NONE;
                                state_q      <= ST_IDLE;
                            end else begin
                                state_q <= ST_PAD;
                            end
                        end
                    end else if (out_free) begin
                        out_vld_q <= 1'b0;
                    end
                end
                ST_PAD: begin
                    if (out_free) begin
                        out_dat_q  <= 8'h00;
                        out_vld_q  <= 1'b1;
                        byte_cnt_q <= byte_cnt_d;
                        out_last_q <= pad_done;
                        if (pad_done) begin
                            rr_ip_last_q <= (grant_q == GNT_IP);
                            grant_q      <= GNT_NONE;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: table of single-frame vectors, directed arbitration and
// mid-frame reset sequences, then randomized traffic against a frame-level scoreboard.
module tb_eth_tx_frame_arbiter;

    localparam int MIN = 60;

    logic       logic_clk = 1'b0;
    logic       logic_rst;
    logic [7:0] arp_tx_data_in;
    logic       arp_tx_valid_in;
    logic       arp_tx_ready_out;
    logic       arp_tx_last_in;
    logic [7:0] ip_tx_data_in;
    logic       ip_tx_valid_in;
    logic       ip_tx_ready_out;
    logic       ip_tx_last_in;
    logic [7:0] mac_rnet_data_out;
    logic       mac_rnet_valid_out;
    logic       mac_rnet_ready_in;
    logic       mac_rnet_last_out;
    logic [1:0] arb_grant_out;

    eth_tx_frame_arbiter #(.MIN_FRAME_BYTES(MIN), .CNT_WIDTH(11)) dut (
        .logic_clk          (logic_clk),
        .logic_rst          (logic_rst),
        .arp_tx_data_in     (arp_tx_data_in),
        .arp_tx_valid_in    (arp_tx_valid_in),
        .arp_tx_ready_out   (arp_tx_ready_out),
        .arp_tx_last_in     (arp_tx_last_in),
        .ip_tx_data_in      (ip_tx_data_in),
        .ip_tx_valid_in     (ip_tx_valid_in),
        .ip_tx_ready_out    (ip_tx_ready_out),
        .ip_tx_last_in      (ip_tx_last_in),
        .mac_rnet_data_out  (mac_rnet_data_out),
        .mac_rnet_valid_out (mac_rnet_valid_out),
        .mac_rnet_ready_in  (mac_rnet_ready_in),
        .mac_rnet_last_out  (mac_rnet_last_out),
        .arb_grant_out      (arb_grant_out)
    );

    always #5 logic_clk = ~logic_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Source drivers: bytes still to be offered.
    logic [7:0] arp_drv_d[$];
    bit         arp_drv_l[$];
    logic [7:0] ip_drv_d[$];
    bit         ip_drv_l[$];
    // Scoreboard: frames expected on the output, per source.
    logic [7:0] exp_arp_b[$];
    int         exp_arp_len[$];
    logic [7:0] exp_ip_b[$];
    int         exp_ip_len[$];
    // Output monitor.
    logic [7:0] mon_buf[$];
    bit         mon_started = 0;
    int         mon_start_cyc = 0;
    int         frames_done = 0;
    int         last_out_len = 0;
    int         last_start_cyc = 0;
    // Stimulus controls.
    bit         arp_en = 0;
    bit         ip_en = 0;
    bit         rand_en = 0;
    int         rdy_mode = 0;
    // Tracking state.
    bit         pend_arp = 0;
    bit         pend_ip = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_dat = 8'h00;
    logic       prev_last = 1'b0;
    int         arp_acc_cnt = 0;
    int         grant_log[$];
    int         zero_runs[$];
    int         zero_run = 0;
    logic [1:0] prev_grant = 2'b00;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] pop_exp_b(input int src);
        logic [7:0] b;
        b = 8'h00;
        if (src == 1) begin
            if (exp_arp_b.size() > 0) b = exp_arp_b.pop_front();
        end else begin
            if (exp_ip_b.size() > 0) b = exp_ip_b.pop_front();
        end
        return b;
    endfunction

    // ARP bytes live in 0x01..0x7F and IP bytes in 0x80..0xFF, so the first byte names the source.
    task automatic push_frame(input int src, input int len, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if (src == 1) begin
                b = rnd ? 8'($urandom_range(1, 127)) : 8'(i + 1);
                arp_drv_d.push_back(b);
                arp_drv_l.push_back(i == len - 1);
                exp_arp_b.push_back(b);
            end else begin
                b = rnd ? 8'($urandom_range(128, 255)) : (8'h80 | 8'(i & 127));
                ip_drv_d.push_back(b);
                ip_drv_l.push_back(i == len - 1);
                exp_ip_b.push_back(b);
            end
        end
        if (src == 1) exp_arp_len.push_back(len);
        else          exp_ip_len.push_back(len);
    endtask

    // Output frame = source bytes, zero-padded to MIN; compare against the scoreboard.
    task automatic finish_frame();
        int src;
        int len;
        int n_exp;
        int bad;
        logic [7:0] eb;
        src = mon_buf[0][7] ? 2 : 1;
        if ((src == 1 && exp_arp_len.size() == 0) || (src == 2 && exp_ip_len.size() == 0)) begin
            check("frame_expected", 0, 1);
        end else begin
            len   = (src == 1) ? exp_arp_len.pop_front() : exp_ip_len.pop_front();
            n_exp = (len > MIN) ? len : MIN;
            check("frame_len", mon_buf.size(), n_exp);
            bad = -1;
            for (int i = 0; i < n_exp; i++) begin
                eb = (i < len) ? pop_exp_b(src) : 8'h00;
                if (bad < 0 && (i >= mon_buf.size() || mon_buf[i] != eb)) bad = i;
            end
            check("frame_data_first_bad_index", bad, -1);
        end
        if (src == 1) pend_arp = 0;
        else          pend_ip = 0;
        last_out_len   = mon_buf.size();
        last_start_cyc = mon_start_cyc;
        frames_done++;
        mon_buf.delete();
    endtask

    task automatic check_ready(input string name, input int s, input logic rdy, input bit pend,
                               input bit out_free);
        if (int'(arb_grant_out) != s) check(name, rdy, 0);
        else if (pend) begin
            if (!(mac_rnet_valid_out && mac_rnet_last_out)) check(name, rdy, 0);
        end else check(name, rdy, out_free);
    endtask

    task automatic sample();
        bit out_free;
        out_free = !mac_rnet_valid_out || mac_rnet_ready_in;
        if (prev_stall)
            check("stall_hold", {mac_rnet_valid_out, mac_rnet_last_out, mac_rnet_data_out},
                  {1'b1, prev_last, prev_dat});
        prev_stall = mac_rnet_valid_out && !mac_rnet_ready_in;
        prev_dat   = mac_rnet_data_out;
        prev_last  = mac_rnet_last_out;
        check_ready("arp_ready", 1, arp_tx_ready_out, pend_arp, out_free);
        check_ready("ip_ready", 2, ip_tx_ready_out, pend_ip, out_free);
        if (arb_grant_out == 2'b00) zero_run++;
        else begin
            if (prev_grant == 2'b00) begin
                grant_log.push_back(int'(arb_grant_out));
                zero_runs.push_back(zero_run);
            end
            zero_run = 0;
        end
        prev_grant = arb_grant_out;
        if (arp_tx_valid_in && arp_tx_ready_out && arp_drv_d.size() > 0) begin
            if (arp_drv_l[0]) pend_arp = 1;
            void'(arp_drv_d.pop_front());
            void'(arp_drv_l.pop_front());
            arp_acc_cnt++;
        end
        if (ip_tx_valid_in && ip_tx_ready_out && ip_drv_d.size() > 0) begin
            if (ip_drv_l[0]) pend_ip = 1;
            void'(ip_drv_d.pop_front());
            void'(ip_drv_l.pop_front());
        end
        if (mac_rnet_valid_out && !mon_started) begin
            mon_started   = 1;
            mon_start_cyc = cyc;
        end
        if (mac_rnet_valid_out && mac_rnet_ready_in) begin
            mon_buf.push_back(mac_rnet_data_out);
            if (mac_rnet_last_out) begin
                finish_frame();
                mon_started = 0;
            end
        end
    endtask

    task automatic cycle();
        if (rand_en) begin
            arp_en = ($urandom % 4) != 0;
            ip_en  = ($urandom % 4) != 0;
        end
        arp_tx_valid_in = arp_en && arp_drv_d.size() > 0;
        arp_tx_data_in  = 8'($urandom);
        arp_tx_last_in  = 1'($urandom);
        if (arp_tx_valid_in) begin
            arp_tx_data_in = arp_drv_d[0];
            arp_tx_last_in = arp_drv_l[0];
        end
        ip_tx_valid_in = ip_en && ip_drv_d.size() > 0;
        ip_tx_data_in  = 8'($urandom);
        ip_tx_last_in  = 1'($urandom);
        if (ip_tx_valid_in) begin
            ip_tx_data_in = ip_drv_d[0];
            ip_tx_last_in = ip_drv_l[0];
        end
        case (rdy_mode)
            0:       mac_rnet_ready_in = 1'b1;
            1:       mac_rnet_ready_in = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: mac_rnet_ready_in = ($urandom % 4) != 0;
        endcase
        @(negedge logic_clk);
        if (!logic_rst) sample();
        @(posedge logic_clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            cycle();
            n++;
        end
        if (frames_done < target) check("wait_frames_timeout", frames_done, target);
    endtask

    // One-cycle synchronous reset; all scoreboards are flushed since the partial frame is dropped.
    task automatic do_reset();
        logic_rst = 1'b1;
        cycle();
        logic_rst = 1'b0;
        arp_drv_d.delete(); arp_drv_l.delete();
        ip_drv_d.delete();  ip_drv_l.delete();
        exp_arp_b.delete(); exp_arp_len.delete();
        exp_ip_b.delete();  exp_ip_len.delete();
        mon_buf.delete();
        mon_started = 0;
        pend_arp    = 0;
        pend_ip     = 0;
        prev_stall  = 0;
        prev_grant  = 2'b00;
        zero_run    = 0;
        check("rst_valid", mac_rnet_valid_out, 0);
        check("rst_last", mac_rnet_last_out, 0);
        check("rst_data", mac_rnet_data_out, 0);
        check("rst_arp_ready", arp_tx_ready_out, 0);
        check("rst_ip_ready", ip_tx_ready_out, 0);
        check("rst_grant", arb_grant_out, 0);
    endtask

    typedef struct {
        int src;
        int len;
        int rmode;
        int exp_len;
        int exp_lat;
    } vec_t;

    initial begin
        vec_t vt[7];
        int   g0;
        int   z0;
        int   start;
        int   n;

        vt[0] = '{src: 1, len: 42,  rmode: 0, exp_len: 60,  exp_lat: 2};
        vt[1] = '{src: 2, len: 100, rmode: 0, exp_len: 100, exp_lat: 2};
        vt[2] = '{src: 1, len: 60,  rmode: 0, exp_len: 60,  exp_lat: 2};
        vt[3] = '{src: 2, len: 59,  rmode: 0, exp_len: 60,  exp_lat: 2};
        vt[4] = '{src: 1, len: 1,   rmode: 0, exp_len: 60,  exp_lat: 2};
        vt[5] = '{src: 2, len: 80,  rmode: 1, exp_len: 80,  exp_lat: 2};
        vt[6] = '{src: 1, len: 61,  rmode: 2, exp_len: 61,  exp_lat: 2};

        logic_rst         = 1'b1;
        arp_tx_data_in    = 8'h00;
        arp_tx_valid_in   = 1'b0;
        arp_tx_last_in    = 1'b0;
        ip_tx_data_in     = 8'h00;
        ip_tx_valid_in    = 1'b0;
        ip_tx_last_in     = 1'b0;
        mac_rnet_ready_in = 1'b1;
        cycle();
        do_reset();

        // Single-frame vectors: padding, pass-through, length boundaries, backpressure.
        arp_en = 1;
        ip_en  = 1;
        for (int v = 0; v < 7; v++) begin
            rdy_mode = vt[v].rmode;
            start    = cyc;
            push_frame(vt[v].src, vt[v].len, 0);
            wait_frames(frames_done + 1, 2000);
            check($sformatf("vec%0d_out_len", v), last_out_len, vt[v].exp_len);
            check($sformatf("vec%0d_latency", v), last_start_cyc - start, vt[v].exp_lat);
            idle(4);
        end

        // Arbitration: both sources continuously valid with 64-byte frames after reset.
        do_reset();
        rdy_mode = 0;
        g0 = grant_log.size();
        z0 = zero_runs.size();
        for (int k = 0; k < 4; k++) begin
            push_frame(1, 64, 1);
            push_frame(2, 64, 1);
        end
        wait_frames(frames_done + 8, 3000);
        check("arb_grant_count", grant_log.size() - g0, 8);
        for (int k = 0; k < 8; k++)
            if (g0 + k < grant_log.size())
                check($sformatf("arb_grant_%0d", k), grant_log[g0 + k], (k % 2 == 0) ? 1 : 2);
        for (int k = 1; k < 8; k++)
            if (z0 + k < zero_runs.size())
                check($sformatf("arb_idle_gap_%0d", k), zero_runs[z0 + k], 1);
        idle(4);

        // Mid-frame reset: leave rr at "ARP served last", then reset inside an ARP frame.
        push_frame(1, 10, 1);
        wait_frames(frames_done + 1, 500);
        idle(2);
        start = arp_acc_cnt;
        push_frame(1, 42, 0);
        n = 0;
        while (arp_acc_cnt - start < 20 && n < 500) begin
            cycle();
            n++;
        end
        check("rst_mid_bytes_taken", arp_acc_cnt - start, 20);
        do_reset();
        g0 = grant_log.size();
        push_frame(1, 10, 1);
        push_frame(2, 10, 1);
        wait_frames(frames_done + 2, 1000);
        check("rst_tie_grant_count", grant_log.size() - g0, 2);
        if (grant_log.size() > g0) check("rst_tie_winner", grant_log[g0], 1);
        push_frame(2, 70, 1);
        wait_frames(frames_done + 1, 1000);
        check("rst_ip70_len", last_out_len, 70);
        idle(4);

        // Randomized traffic with random gaps and random output backpressure.
        rand_en  = 1;
        rdy_mode = 2;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 10; k++) begin
                push_frame(1, int'($urandom_range(1, 90)), 1);
                push_frame(2, int'($urandom_range(1, 90)), 1);
            end
            wait_frames(frames_done + 20, 20000);
        end
        rand_en = 0;
        idle(4);
        check("leftover_frames", exp_arp_len.size() + exp_ip_len.size(), 0);
        check("leftover_src_bytes", arp_drv_d.size() + ip_drv_d.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
